id_ex_stage: RTL

ID/EX pipeline stage of the PipelineCPU, sitting directly upstream of the ALU. It registers one decoded instruction and resolves operand forwarding from EX/MEM and MEM/WB. It detects load-use hazards and inserts a single bubble for each one. It drives the ALU operand and opcode inputs through a valid/ready handshake and supports branch flush.

---
 rtl/id_ex_stage_if.sv | 69 ++++++
 rtl/id_ex_stage.sv | 130 +++++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// ============================================================================
// Module      : id_ex_stage_if
// Description : Decode-side, forwarding and ALU-side signals of the ID/EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  flush;
  logic                  id_valid;
  logic                  id_ready;
  logic [3:0]            id_alu_op;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [DATA_WIDTH-1:0] id_rs_data;
  logic [DATA_WIDTH-1:0] id_rt_data;
  logic [DATA_WIDTH-1:0] id_imm;
  logic                  id_use_imm;
  logic                  id_shamt_imm;
  logic [DATA_WIDTH-1:0] id_in3;
  logic [DATA_WIDTH-1:0] id_in4;
  logic                  id_sel;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  exmem_reg_write;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic [DATA_WIDTH-1:0] exmem_result;
  logic                  memwb_reg_write;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic [DATA_WIDTH-1:0] memwb_result;
  logic                  ex_valid;
  logic                  ex_ready;
  logic [3:0]            ex_alu_op;
  logic                  ex_sel;
  logic [DATA_WIDTH-1:0] ex_in1;
  logic [DATA_WIDTH-1:0] ex_in2;
  logic [DATA_WIDTH-1:0] ex_in3;
  logic [DATA_WIDTH-1:0] ex_in4;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic [15:0]           stall_count;

  // Environment side: drives decode, forwarding sources and ALU readiness.
  modport master (
    output flush, id_valid, id_alu_op, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_shamt_imm, id_in3, id_in4, id_sel, id_reg_write,
           id_mem_read, exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write,
           memwb_rd, memwb_result, ex_ready,
    input  id_ready, ex_valid, ex_alu_op, ex_sel, ex_in1, ex_in2, ex_in3, ex_in4,
           ex_rd, ex_reg_write, ex_mem_read, stall_count
  );

  // Stage side.
  modport slave (
    input  flush, id_valid, id_alu_op, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_shamt_imm, id_in3, id_in4, id_sel, id_reg_write,
           id_mem_read, exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write,
           memwb_rd, memwb_result, ex_ready,
    output id_ready, ex_valid, ex_alu_op, ex_sel, ex_in1, ex_in2, ex_in3, ex_in4,
           ex_rd, ex_reg_write, ex_mem_read, stall_count
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with forwarding, load-use stall and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  typedef struct packed {
    logic [3:0]            op;
    logic                  sel;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] imm;
    logic                  use_imm;
    logic                  shamt_imm;
    logic [DATA_WIDTH-1:0] in3;
    logic [DATA_WIDTH-1:0] in4;
    logic                  reg_write;
    logic                  mem_read;
  } entry_t;

  logic        valid_q, valid_d;
  entry_t      ent_q, ent_d;
  logic [15:0] stall_q, stall_d;

  logic                  luh;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] fwd_rs;
  logic [DATA_WIDTH-1:0] fwd_rt;

  // A load in EX stalls any offered instruction that actually reads its rd.
  always_comb begin
    luh = valid_q && ent_q.mem_read && (ent_q.rd != '0) && bus.id_valid &&
          (((ent_q.rd == bus.id_rs) && !bus.id_shamt_imm) ||
           ((ent_q.rd == bus.id_rt) && !bus.id_use_imm));
  end

  assign bus.id_ready = !bus.flush && !luh && (!valid_q || bus.ex_ready);
  assign xfer         = bus.id_valid && bus.id_ready;

  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    stall_d = stall_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (xfer) begin
      valid_d         = 1'b1;
      ent_d.op        = bus.id_alu_op;
      ent_d.sel       = bus.id_sel;
      ent_d.rs        = bus.id_rs;
      ent_d.rt        = bus.id_rt;
      ent_d.rd        = bus.id_rd;
      ent_d.rs_data   = bus.id_rs_data;
      ent_d.rt_data   = bus.id_rt_data;
      ent_d.imm       = bus.id_imm;
      ent_d.use_imm   = bus.id_use_imm;
      ent_d.shamt_imm = bus.id_shamt_imm;
      ent_d.in3       = bus.id_in3;
      ent_d.in4       = bus.id_in4;
      ent_d.reg_write = bus.id_reg_write;
      ent_d.mem_read  = bus.id_mem_read;
    end else if (valid_q && bus.ex_ready) begin
      valid_d = 1'b0;
    end
    if (luh && !bus.flush && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
      stall_q <= stall_d;
    end
  end

  // EX/MEM wins over MEM/WB; register 0 is hard-wired and never forwarded.
  always_comb begin
    fwd_rs = ent_q.rs_data;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == ent_q.rs)) begin
      fwd_rs = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == ent_q.rs)) begin
      fwd_rs = bus.memwb_result;
    end
  end

  always_comb begin
    fwd_rt = ent_q.rt_data;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == ent_q.rt)) begin
      fwd_rt = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == ent_q.rt)) begin
      fwd_rt = bus.memwb_result;
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_alu_op    = ent_q.op;
  assign bus.ex_sel       = ent_q.sel;
  assign bus.ex_in1       = ent_q.shamt_imm ? {{(DATA_WIDTH-5){1'b0}}, ent_q.imm[10:6]} : fwd_rs;
  assign bus.ex_in2       = ent_q.use_imm ? ent_q.imm : fwd_rt;
  assign bus.ex_in3       = ent_q.in3;
  assign bus.ex_in4       = ent_q.in4;
  assign bus.ex_rd        = ent_q.rd;
  assign bus.ex_reg_write = ent_q.reg_write;
  assign bus.ex_mem_read  = ent_q.mem_read;
  assign bus.stall_count  = stall_q;

endmodule

`default_nettype wire
